// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Instruction-memory write initiator. Receives a byte stream over
//            valid/ready, reads a 32-bit little-endian word count, then writes
//            that many little-endian words sequentially from BASEADDR. The
//            core is held in reset until the image is complete.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASEADDR  = 32'h01000000,
  parameter int                MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int                CW          = $clog2(MAX_WORDS + 1);
  localparam logic [31:0]       C_MAX_N     = 32'(MAX_WORDS);
  localparam logic [AWIDTH-1:0] C_ADDR_STEP = AWIDTH'(4);

  localparam logic [2:0] C_ST_HDR   = 3'd0;
  localparam logic [2:0] C_ST_LOAD  = 3'd1;
  localparam logic [2:0] C_ST_WRITE = 3'd2;
  localparam logic [2:0] C_ST_DONE  = 3'd3;
  localparam logic [2:0] C_ST_ERR   = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q,      asm_d;       // bytes 0..2 of the current group
  logic [31:0]       len_q,      len_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [AWIDTH-1:0] addr_q,     addr_d;
  logic [DWIDTH-1:0] data_q,     data_d;

  logic        w_xfer;
  logic        w_group_end;
  logic [31:0] w_word;
  logic [CW-1:0] w_cnt_inc;
  logic        w_last_word;

  assign w_xfer      = byte_valid_i && byte_ready_o;
  assign w_group_end = w_xfer && (byte_idx_q == 2'd3);
  // The 4th byte completes the word straight from the input, saving a cycle.
  assign w_word      = {byte_i, asm_q};
  assign w_cnt_inc   = word_cnt_q + CW'(1);
  assign w_last_word = (32'(w_cnt_inc) == len_q);

  // State register; rst takes priority over any concurrent byte transfer.
  always_ff @(posedge clk) begin
    if (rst) state_q <= C_ST_HDR;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_HDR: begin
        if (w_group_end) begin
          if (w_word == 32'd0)        state_d = C_ST_DONE;
          else if (w_word > C_MAX_N)  state_d = C_ST_ERR;
          else                        state_d = C_ST_LOAD;
        end
      end
      C_ST_LOAD:  if (w_group_end) state_d = C_ST_WRITE;
      C_ST_WRITE: state_d = w_last_word ? C_ST_DONE : C_ST_LOAD;
      C_ST_DONE:  state_d = C_ST_DONE;
      C_ST_ERR:   state_d = C_ST_ERR;
      default:    state_d = C_ST_HDR;
    endcase
  end

  // Outputs decoded from state; ready is also forced low while rst is high.
  always_comb begin
    byte_ready_o = 1'b0;
    write_en_o   = 1'b0;
    core_rst_o   = 1'b1;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      C_ST_HDR, C_ST_LOAD: byte_ready_o = !rst;
      C_ST_WRITE:          write_en_o   = 1'b1;
      C_ST_DONE: begin
        core_rst_o = 1'b0;
        done_o     = 1'b1;
      end
      C_ST_ERR:            error_o      = 1'b1;
      default:             byte_ready_o = 1'b0;
    endcase
  end

  assign read_en_o = 1'b0;
  assign addr_o    = addr_q;
  assign data_o    = data_q;

  // Datapath next values: byte assembly, length capture, word/address stepping.
  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    if (w_xfer) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: asm_d        = asm_q;
      endcase
    end
    if (w_group_end && (state_q == C_ST_HDR))  len_d  = w_word;
    if (w_group_end && (state_q == C_ST_LOAD)) data_d = w_word;
    if (state_q == C_ST_WRITE) begin
      word_cnt_d = w_cnt_inc;
      addr_d     = addr_q + C_ADDR_STEP;
    end
  end

  // Datapath registers; reset discards any partial word and the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      len_q      <= 32'd0;
      word_cnt_q <= '0;
      addr_q     <= BASEADDR;
      data_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

endmodule
`default_nettype wire
